// File: rtl/a_io_l3_in_serialize_a_m_axi_read_splitter.sv
// AXI read request splitter: breaks a beat-counted request into bursts that
// respect MAX_BURST and never cross a 4 KB page.
module a_io_l3_in_serialize_a_m_axi_read_splitter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 32,
    parameter int DATA_BYTES = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [LEN_WIDTH-1:0]  s_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [7:0]            m_len,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy
);

    localparam int LOG_DB = $clog2(DATA_BYTES);
    localparam int CW     = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(DATA_BYTES - 1);
    localparam logic [12:0] MAX_B = 13'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr, addr_d;
    logic [LEN_WIDTH-1:0]  rem, rem_d, rem_next;
    logic [12:0]           page_bytes, page_beats, cap;
    logic [CW-1:0]         rem_x, cap_x;
    logic [8:0]            beats, beats_m1;

    // Beats left before the next 4 KB page, capped by MAX_BURST and rem
    always_comb begin
        page_bytes = 13'h1000 - {1'b0, cur_addr[11:0]};
        page_beats = page_bytes >> LOG_DB;
        cap        = (page_beats < MAX_B) ? page_beats : MAX_B;
        rem_x      = CW'(rem);
        cap_x      = CW'(cap);
        beats      = (rem_x < cap_x) ? rem_x[8:0] : cap[8:0];
        beats_m1   = beats - 9'd1;
    end

    assign s_ready = (state_q == IDLE);
    assign m_valid = (state_q == ISSUE);
    assign busy    = (state_q != IDLE);
    assign m_addr  = cur_addr;
    assign m_len   = (state_q == ISSUE) ? beats_m1[7:0] : 8'd0;

    always_comb begin
        state_d  = state_q;
        addr_d   = cur_addr;
        rem_d    = rem;
        rem_next = rem - LEN_WIDTH'(beats);
        unique case (state_q)
            IDLE: begin
                if (s_valid && s_len != '0) begin
                    addr_d  = s_addr & ADDR_MASK;
                    rem_d   = s_len;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (m_ready) begin
                    addr_d = cur_addr + (ADDR_WIDTH'(beats) << LOG_DB);
                    rem_d  = rem_next;
                    if (rem_next == '0) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_addr <= '0;
            rem      <= '0;
        end else begin
            state_q  <= state_d;
            cur_addr <= addr_d;
            rem      <= rem_d;
        end
    end

endmodule

// File: tb/tb_a_io_l3_in_serialize_a_m_axi_read_splitter.sv
// Scoreboard bench for the AXI read splitter: expected bursts are queued
// when a request is driven and compared as the DUT presents them.
module tb_a_io_l3_in_serialize_a_m_axi_read_splitter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_addr;
    logic [31:0] s_len;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    logic        m_valid;
    logic        m_ready;
    logic        busy;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  l;
    } burst_t;

    burst_t exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    a_io_l3_in_serialize_a_m_axi_read_splitter dut (
        .clk     (clk),
        .reset   (reset),
        .s_addr  (s_addr),
        .s_len   (s_len),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_addr  (m_addr),
        .m_len   (m_len),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic push(input logic [31:0] a, input logic [7:0] l);
        burst_t b;
        b.a = a;
        b.l = l;
        exp_q.push_back(b);
    endtask

    // Returns at the negedge after the accepting edge
    task automatic send(input logic [31:0] a, input logic [31:0] l);
        @(negedge clk);
        s_addr  = a;
        s_len   = l;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        s_addr  = $urandom;
        s_len   = $urandom;
    endtask

    task automatic run(input int stall);
        int held = 0;
        int gap  = 0;
        int cyc  = 0;
        bit started = 0;
        m_ready = (stall == 0);
        while (exp_q.size() > 0) begin
            if (cyc > 300) begin
                chk("timeout", 1, 0);
                exp_q.delete();
                break;
            end
            if (m_valid) begin
                started = 1;
                chk("m_addr", m_addr, exp_q[0].a);
                chk("m_len", m_len, exp_q[0].l);
                if (!m_ready) begin
                    held++;
                    if (held >= stall) m_ready = 1'b1;
                end
                if (m_ready) void'(exp_q.pop_front());
            end else if (started) begin
                gap++;
            end
            cyc++;
            @(negedge clk);
        end
        chk("gap", gap, 0);
        chk("hold", held, stall);
        chk("done_valid", m_valid, 0);
        chk("done_ready", s_ready, 0);
        chk("done_busy", busy, 1);
        @(negedge clk);
        chk("idle_ready", s_ready, 1);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        reset   = 1'b1;
        s_addr  = '0;
        s_len   = '0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_len", m_len, 0);

        // 40 beats from a page start: 16 + 16 + 8
        push(32'h1000, 8'd15);
        push(32'h1040, 8'd15);
        push(32'h1080, 8'd7);
        send(32'h1000, 32'd40);
        run(0);

        // crosses a 4 KB page after two beats
        push(32'h0FF8, 8'd1);
        push(32'h1000, 8'd7);
        send(32'h0FF8, 32'd10);
        run(0);

        // unaligned single beat
        push(32'h2000, 8'd0);
        send(32'h2003, 32'd1);
        run(0);

        // zero-length request is dropped
        send(32'h5000, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("len0_valid", m_valid, 0);
            chk("len0_ready", s_ready, 1);
            chk("len0_busy", busy, 0);
            @(negedge clk);
        end

        // first burst back-pressured for 5 cycles
        push(32'h1000, 8'd15);
        push(32'h1040, 8'd15);
        push(32'h1080, 8'd7);
        send(32'h1000, 32'd40);
        run(5);

        // reset mid-request abandons remaining bursts
        m_ready = 1'b1;
        send(32'h1000, 32'd40);
        chk("pre_rst_valid", m_valid, 1);
        chk("pre_rst_addr", m_addr, 32'h1000);
        chk("pre_rst_len", m_len, 8'd15);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_valid", m_valid, 0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", s_ready, 1);
        chk("post_rst_addr", m_addr, 0);
        chk("post_rst_len", m_len, 0);
        chk("post_rst_valid", m_valid, 0);
        push(32'h3000, 8'd15);
        send(32'h3000, 32'd16);
        run(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
